high_low_out_buf: RTL
=====================

Name: high_low_out_buf

Overview:
- Output buffer directly downstream of highLowCpu.
- Captures the CPU's 1-bit high_o and low_o streams into two independent FIFOs, each drained by its own ready/valid consumer.
- Low-side and high-side state are strictly partitioned, so the buffer preserves the CPU's non-interference property: nothing on the low drain side may depend on any high-side input.

Parameters:
- DEPTH, 8: entries per FIFO; power of 2, minimum 2.
- DATA_W, 1: width of each data word; matches the CPU output width.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- high_d  input  DATA_W  high_o from the CPU.
- high_wr  input  1  write strobe for high_d.
- low_d  input  DATA_W  low_o from the CPU.
- low_wr  input  1  write strobe for low_d.
- high_valid  output  1  high FIFO non-empty.
- high_data  output  DATA_W  head of the high FIFO.
- high_ready  input  1  high consumer accepts the head.
- low_valid  output  1  low FIFO non-empty.
- low_data  output  DATA_W  head of the low FIFO.
- low_ready  input  1  low consumer accepts the head.
- high_ovf  output  1  sticky: a high write was dropped.
- low_ovf  output  1  sticky: a low write was dropped.
- high_drops  output  8  saturating high drop count (feature-gated).
- low_drops  output  8  saturating low drop count (feature-gated).

Behaviour:
- Two identical FIFO channels, X in {high, low}.
- Each channel has its own storage, write/read pointers of log2(DEPTH)+1 bits, and occupancy count. No logic is shared between channels.
- Reset (async assert, released synchronously on clk): pointers, count, ovf and drops go to 0. All outputs are 0 while reset is asserted. Storage contents are don't-care.
- Pop: X_valid && X_ready, evaluated on the rising edge; the read pointer advances.
- X_valid = (count != 0). X_data = mem[rd_ptr], combinational from storage.
- Push latency: data written at edge N is visible on X_data/X_valid after edge N, i.e. one cycle, no fall-through.
- Write accepted when X_wr && (count < DEPTH || pop this cycle).
  - Full plus simultaneous pop: accepted, count stays at DEPTH.
- Overflow: X_wr on a full FIFO with no pop drops the data. The pointer is unchanged, X_ovf sets and holds until reset, and X_drops increments, saturating at 255.
- Empty: X_ready with X_valid=0 is ignored. The pointer and count are unchanged.
- Simultaneous push and pop at 0 < count < DEPTH: count unchanged, both pointers advance.
- Wrap-around: pointers wrap modulo 2*DEPTH. Full = MSBs differ and lower bits equal.
- Reset mid-operation: all queued data is discarded; X_valid is 0 on the first cycle after reset release.
- Non-interference rule: low_valid, low_data, low_ovf and low_drops are functions only of reset, low_d, low_wr and low_ready history. The high channel may not gate, stall or reorder the low channel.
- Formal check: two instances share the low inputs and receive differing high inputs; all low outputs must be equal every cycle after reset.

Optional Feature:
- Macro: HIGH_LOW_OUT_BUF_DROP_CNT_EN.
- Defined: high_drops and low_drops are implemented as the 8-bit saturating counters described above.
- Undefined: the counters are not built, and high_drops and low_drops are tied to 0. The ovf flags are unaffected.

Test Plan:
- Fill/drain: reset, then write low_d = 1,0,1,1 on 4 consecutive cycles with low_ready=0 -> low_valid=1 one cycle after the first write. Then low_ready=1 -> low_data reads 1,0,1,1 in order, and low_valid=0 after the 4th pop.
- Overflow: 9 low writes with low_ready=0 and DEPTH=8 -> the 9th is dropped, low_ovf=1, and low_drops=1 with the macro defined (0 without). The contents are the first 8 values.
- Full with simultaneous pop: FIFO full, then low_wr=1 and low_ready=1 in the same cycle -> write accepted, count stays 8, low_ovf stays 0. The new value emerges 8 pops later.
- Isolation: random high_d/high_wr/high_ready, including high overflow, against a fixed low stimulus -> low outputs are identical cycle-by-cycle to a run with high inputs held at 0, and high_ovf=1 never perturbs the low side.
- Reset mid-op: 5 entries queued, assert reset for 1 cycle -> on release, all valids, ovfs and drops are 0. The next write/read returns the new data only.
- Wrap: 20 push/pop pairs at occupancy 3 -> FIFO ordering is preserved across pointer wrap, and count never deviates from 3.

Source files
------------

// File: rtl/high_low_out_buf.sv
// Dual independent output FIFOs (high/low) behind highLowCpu; the two channels share no logic.
// Optional saturating drop counters are built when HIGH_LOW_OUT_BUF_DROP_CNT_EN is defined.

module high_low_out_buf_chan #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] wr_d,
    input  logic              wr,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              ovf,
    output logic [7:0]        drops
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              full_s, pop_s, accept_s, drop_s;

    // Pointer, occupancy and overflow next-state; a pop frees the slot a same-cycle write fills.
    always_comb begin
        pop_s    = (count_q != PTR_ZERO) && ready;
        full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        accept_s = wr && (!full_s || pop_s);
        drop_s   = wr && full_s && !pop_s;
        wr_ptr_d = accept_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({accept_s, pop_s})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q | drop_s;
    end

    // Control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= PTR_ZERO;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: it is only read when count is non-zero.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_d;
        end
    end

    assign valid = (count_q != PTR_ZERO);
    assign data  = reset ? {DATA_W{1'b0}} : mem_q[rd_ptr_q[AW-1:0]];
    assign ovf   = ovf_q;

`ifdef HIGH_LOW_OUT_BUF_DROP_CNT_EN
    logic [7:0] drops_q, drops_d;

    // Saturating drop counter.
    always_comb begin
        if (drop_s && (drops_q != 8'hFF)) begin
            drops_d = drops_q + 8'd1;
        end else begin
            drops_d = drops_q;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drops_q <= 8'd0;
        end else begin
            drops_q <= drops_d;
        end
    end

    assign drops = drops_q;
`else
    assign drops = 8'd0;
`endif

endmodule

module high_low_out_buf #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] high_d,
    input  logic              high_wr,
    input  logic [DATA_W-1:0] low_d,
    input  logic              low_wr,
    output logic              high_valid,
    output logic [DATA_W-1:0] high_data,
    input  logic              high_ready,
    output logic              low_valid,
    output logic [DATA_W-1:0] low_data,
    input  logic              low_ready,
    output logic              high_ovf,
    output logic              low_ovf,
    output logic [7:0]        high_drops,
    output logic [7:0]        low_drops
);
    high_low_out_buf_chan #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_high (
        .clk   (clk),
        .reset (reset),
        .wr_d  (high_d),
        .wr    (high_wr),
        .ready (high_ready),
        .valid (high_valid),
        .data  (high_data),
        .ovf   (high_ovf),
        .drops (high_drops)
    );

    high_low_out_buf_chan #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_low (
        .clk   (clk),
        .reset (reset),
        .wr_d  (low_d),
        .wr    (low_wr),
        .ready (low_ready),
        .valid (low_valid),
        .data  (low_data),
        .ovf   (low_ovf),
        .drops (low_drops)
    );
endmodule
